// File: rtl/intpol2_ctrl_pkg.sv
// Shared types and defaults for the x4 I/Q interpolator frame sequencer.
// Optional watchdog is enabled by defining INTPOL2_CTRL_WDOG_EN.
package intpol2_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_t;

  localparam int PHASES       = 4;
  localparam int DEF_LEN_W    = 16;
  localparam int DEF_PIPE_LAT = 2;
  localparam int DEF_WDOG_W   = 16;

  localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

endpackage

// File: rtl/intpol2_d4_seq_ctrl_if.sv
// Control/status bundle between the frame sequencer, the I/Q FIFOs,
// the interpolator datapath and the MCU register block.
interface intpol2_d4_seq_ctrl_if #(
  parameter int LEN_W  = 16,
  parameter int WDOG_W = 16
);

  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  conf_len;
  logic [WDOG_W-1:0] wdog_limit;
  logic              int_ack;
  logic              fifo_empty_i;
  logic              fifo_empty_q;
  logic              fifo_rd;
  logic              afull_i;
  logic              afull_q;
  logic              ip_load;
  logic              ip_en;
  logic [1:0]        ip_phase;
  logic              write_en_o;
  logic              busy;
  logic              done;
  logic              int_req;
  logic [LEN_W-1:0]  smp_cnt;
  logic [LEN_W-1:0]  underrun_cnt;
  logic              err_timeout;

  // Sequencer side
  modport master (
    input  start, abort, conf_len, wdog_limit, int_ack,
    input  fifo_empty_i, fifo_empty_q, afull_i, afull_q,
    output fifo_rd, ip_load, ip_en, ip_phase, write_en_o,
    output busy, done, int_req, smp_cnt, underrun_cnt, err_timeout
  );

  // Environment side (MCU, FIFOs, datapath)
  modport slave (
    output start, abort, conf_len, wdog_limit, int_ack,
    output fifo_empty_i, fifo_empty_q, afull_i, afull_q,
    input  fifo_rd, ip_load, ip_en, ip_phase, write_en_o,
    input  busy, done, int_req, smp_cnt, underrun_cnt, err_timeout
  );

endinterface

// File: rtl/intpol2_ctrl_vsr.sv
// Stallable valid shift register tracking samples in flight through the
// interpolator pipeline; provides the tail strobe and drain status.
module intpol2_ctrl_vsr #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  input  logic din,
  output logic tail,
  output logic empty,
  output logic drainNext
);

  logic [DEPTH-1:0] stagesReg;
  logic [DEPTH-1:0] stagesNext;
  logic [DEPTH-1:0] bodyBits;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stagesNext[gi] = din;
      end else begin : g_body
        assign stagesNext[gi] = stagesReg[gi-1];
      end
      // Everything except the tail must be clear for the next shift to drain
      if (gi == DEPTH - 1) begin : g_tail
        assign bodyBits[gi] = 1'b0;
      end else begin : g_keep
        assign bodyBits[gi] = stagesReg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stagesReg <= '0;
    end else if (!stall) begin
      stagesReg <= stagesNext;
    end
  end

  assign tail      = stagesReg[DEPTH-1];
  assign empty     = ~|stagesReg;
  // Valid only while din is held low (draining phase)
  assign drainNext = ~stall & ~|bodyBits;

endmodule

// File: rtl/intpol2_d4_seq_ctrl.sv
// Frame sequencer for the x4 I/Q linear interpolator: pops input pairs, paces
// them at one per 4 output slots, aligns write strobes. Watchdog: INTPOL2_CTRL_WDOG_EN.
module intpol2_d4_seq_ctrl
  import intpol2_ctrl_pkg::*;
#(
  parameter int LEN_W    = DEF_LEN_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int WDOG_W   = DEF_WDOG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  intpol2_d4_seq_ctrl_if.master   bus
);

  ctrl_state_t      stateReg;
  logic [1:0]       phaseReg;
  logic [LEN_W-1:0] lenReg;
  logic [LEN_W-1:0] smpCntReg;
  logic [LEN_W-1:0] undCntReg;
  logic             ipLoadReg;
  logic             doneReg;
  logic             intReqReg;
  logic             errTimeoutReg;

  logic stall;
  logic empty;
  logic inRun;
  logic ipEn;
  logic lastPhase;
  logic moreSmp;
  logic fifoRd;
  logic killNow;
  logic wdogHit;
  logic vsrTail;
  logic vsrEmpty;
  logic vsrDrainNext;
  logic flushEnd;

  assign stall     = bus.afull_i | bus.afull_q;
  assign empty     = bus.fifo_empty_i | bus.fifo_empty_q;
  assign killNow   = bus.abort | wdogHit;
  assign inRun     = (stateReg == RUN);
  assign ipEn      = (inRun || stateReg == FLUSH) && !stall && !killNow;
  assign lastPhase = ipEn && (phaseReg == LAST_PHASE);
  assign moreSmp   = (smpCntReg < lenReg);
  assign flushEnd  = vsrEmpty | vsrDrainNext;

  // Initial pop from PRIME, or prefetch of the next pair on the last phase
  assign fifoRd = !killNow && !empty &&
                  ((stateReg == PRIME) || (inRun && lastPhase && moreSmp));

  intpol2_ctrl_vsr #(
    .DEPTH (PIPE_LAT)
  ) u_vsr (
    .clk       (clk),
    .rst       (rst),
    .clr       (killNow),
    .stall     (stall),
    .din       (inRun & ipEn),
    .tail      (vsrTail),
    .empty     (vsrEmpty),
    .drainNext (vsrDrainNext)
  );

`ifdef INTPOL2_CTRL_WDOG_EN
  logic [WDOG_W-1:0] wdogCntReg;
  logic [WDOG_W:0]   wdogInc;
  logic              waiting;

  assign waiting = ((stateReg == PRIME) && empty) ||
                   ((stateReg == RUN || stateReg == FLUSH) && stall);
  assign wdogInc = {1'b0, wdogCntReg} + 1'b1;
  // A zero limit disables the watchdog rather than firing immediately
  assign wdogHit = waiting && (bus.wdog_limit != '0) &&
                   (wdogInc >= {1'b0, bus.wdog_limit});

  always_ff @(posedge clk) begin
    if (rst || !waiting || killNow) begin
      wdogCntReg <= '0;
    end else begin
      wdogCntReg <= wdogInc[WDOG_W-1:0];
    end
  end
`else
  logic [WDOG_W-1:0] unusedWdog;
  assign unusedWdog = bus.wdog_limit;
  assign wdogHit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg      <= IDLE;
      phaseReg      <= '0;
      lenReg        <= '0;
      smpCntReg     <= '0;
      undCntReg     <= '0;
      ipLoadReg     <= 1'b0;
      doneReg       <= 1'b0;
      intReqReg     <= 1'b0;
      errTimeoutReg <= 1'b0;
    end else begin
      doneReg   <= 1'b0;
      ipLoadReg <= fifoRd;
      if (ipLoadReg) smpCntReg <= smpCntReg + 1'b1;
      if (ipEn)      phaseReg  <= phaseReg + 1'b1;
      if (bus.int_ack) intReqReg <= 1'b0;

      if (killNow) begin
        stateReg <= IDLE;
        if (wdogHit) begin
          errTimeoutReg <= 1'b1;
          intReqReg     <= 1'b1;
        end
      end else begin
        case (stateReg)
          IDLE: begin
            if (bus.start) begin
              intReqReg     <= 1'b0;
              errTimeoutReg <= 1'b0;
              smpCntReg     <= '0;
              undCntReg     <= '0;
              phaseReg      <= '0;
              lenReg        <= bus.conf_len;
              if (bus.conf_len == '0) begin
                doneReg   <= 1'b1;
                intReqReg <= 1'b1;
              end else begin
                stateReg <= PRIME;
              end
            end
          end
          PRIME: begin
            if (!empty) begin
              stateReg <= RUN;
              phaseReg <= '0;
            end
          end
          RUN: begin
            if (lastPhase) begin
              if (!moreSmp) begin
                stateReg <= FLUSH;
              end else if (empty) begin
                stateReg  <= PRIME;
                undCntReg <= undCntReg + 1'b1;
              end
            end
          end
          FLUSH: begin
            if (flushEnd) begin
              stateReg  <= IDLE;
              doneReg   <= 1'b1;
              intReqReg <= 1'b1;
            end
          end
          default: stateReg <= IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_rd      = fifoRd;
  assign bus.ip_load      = ipLoadReg;
  assign bus.ip_en        = ipEn;
  assign bus.ip_phase     = phaseReg;
  assign bus.write_en_o   = vsrTail & ~stall;
  assign bus.busy         = (stateReg != IDLE);
  assign bus.done         = doneReg;
  assign bus.int_req      = intReqReg;
  assign bus.smp_cnt      = smpCntReg;
  assign bus.underrun_cnt = undCntReg;
  assign bus.err_timeout  = errTimeoutReg;

endmodule

// File: tb/tb_intpol2_d4_seq_ctrl.sv
// Self-checking bench for intpol2_d4_seq_ctrl: frame scenario table with a
// scoreboard queue, plus hand-written interrupt and watchdog sequences.
module tb_intpol2_d4_seq_ctrl;

  localparam int LEN_W    = 16;
  localparam int WDOG_W   = 16;
  localparam int PIPE_LAT = 2;
  localparam int NVEC     = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intpol2_d4_seq_ctrl_if #(.LEN_W(LEN_W), .WDOG_W(WDOG_W)) bus ();

  intpol2_d4_seq_ctrl #(
    .LEN_W    (LEN_W),
    .PIPE_LAT (PIPE_LAT),
    .WDOG_W   (WDOG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int len;
    int afLo;      int afHi;
    int emLo;      int emHi;
    int abortAt;   int restartAt;
    int expDone;   int expStr;
    int expFw;     int expLw;
    int expPops;   int expUnder;
    int expSmp;    int expPh5;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t expQ [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.int_ack      = 1'b0;
    bus.afull_i      = 1'b0;
    bus.afull_q      = 1'b0;
    bus.fifo_empty_i = 1'b0;
    bus.fifo_empty_q = 1'b0;
  endtask

  // Cycle 0 is the cycle in which start is driven high
  task automatic runFrame(input int idx, input vec_t v);
    int doneAt, doneCnt, str, fw, lw, pops, ph5, intAfter, busyAbort;
    vec_t e;
    doneAt = -1; doneCnt = 0; str = 0; fw = -1; lw = -1; pops = 0;
    ph5 = -1; intAfter = -1; busyAbort = -1;
    expQ.push_back(v);
    for (int c = 0; c < 60; c++) begin
      bus.start        = (c == 0) || (c == v.restartAt);
      bus.conf_len     = (c == 0) ? LEN_W'(v.len) : LEN_W'(5);
      bus.abort        = (c == v.abortAt);
      bus.afull_i      = (c >= v.afLo) && (c <= v.afHi);
      bus.fifo_empty_i = (c >= v.emLo) && (c <= v.emHi);
      #1;
      if (bus.fifo_rd) pops++;
      if (bus.write_en_o) begin
        str++;
        if (fw < 0) fw = c;
        lw = c;
      end
      if (c == 5) ph5 = int'(bus.ip_phase);
      if (doneAt >= 0 && c == doneAt + 1) intAfter = int'(bus.int_req);
      if (c == v.abortAt + 1) busyAbort = int'(bus.busy);
      if (bus.done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = c;
      end
      tick();
      if (doneAt >= 0 && c >= doneAt + 3) break;
    end
    idleInputs();
    e = expQ.pop_front();
    $display("frame %0d len=%0d done@%0d strobes=%0d wr=%0d..%0d pops=%0d under=%0d",
             idx, e.len, doneAt, str, fw, lw, pops, int'(bus.underrun_cnt));
    check($sformatf("f%0d_done_at", idx), doneAt, e.expDone);
    check($sformatf("f%0d_done_cnt", idx), doneCnt, (e.expDone >= 0) ? 1 : 0);
    check($sformatf("f%0d_strobes", idx), str, e.expStr);
    check($sformatf("f%0d_first_wr", idx), fw, e.expFw);
    check($sformatf("f%0d_last_wr", idx), lw, e.expLw);
    check($sformatf("f%0d_pops", idx), pops, e.expPops);
    check($sformatf("f%0d_underrun", idx), int'(bus.underrun_cnt), e.expUnder);
    check($sformatf("f%0d_smp_cnt", idx), int'(bus.smp_cnt), e.expSmp);
    check($sformatf("f%0d_busy_end", idx), int'(bus.busy), 0);
    if (e.expPh5 >= 0)  check($sformatf("f%0d_phase_c5", idx), ph5, e.expPh5);
    if (e.expDone >= 0) check($sformatf("f%0d_int_req", idx), intAfter, 1);
    if (e.abortAt >= 0) check($sformatf("f%0d_busy_after_abort", idx), busyAbort, 0);
  endtask

  initial begin
    //         len afLo afHi emLo emHi abrt rstrt done str fw  lw pops und smp ph5
    vecs[0] = '{1, -1,  -2,  -1,  -2,  -1,  -1,   8,   4,  4,  7,  1,  0,  1,  3};
    vecs[1] = '{3, -1,  -2,  -1,  -2,  -1,  -1,  16,  12,  4, 15,  3,  0,  3,  3};
    vecs[2] = '{1,  3,   4,  -1,  -2,  -1,  -1,  10,   4,  6,  9,  1,  0,  1,  1};
    vecs[3] = '{2, -1,  -2,   5,   5,  -1,  -1,  13,   8,  4, 12,  2,  1,  2,  3};
    vecs[4] = '{4, -1,  -2,  -1,  -2,   3,  -1,  -1,   0, -1, -1,  1,  0,  1, -1};
    vecs[5] = '{0, -1,  -2,  -1,  -2,  -1,  -1,   1,   0, -1, -1,  0,  0,  0, -1};
    vecs[6] = '{2, -1,  -2,  -1,  -2,  -1,   3,  12,   8,  4, 11,  2,  0,  2,  3};

    rst            = 1'b1;
    bus.conf_len   = '0;
    bus.wdog_limit = WDOG_W'(16);
    idleInputs();
    repeat (3) tick();

    check("rst_busy",     int'(bus.busy), 0);
    check("rst_done",     int'(bus.done), 0);
    check("rst_int_req",  int'(bus.int_req), 0);
    check("rst_fifo_rd",  int'(bus.fifo_rd), 0);
    check("rst_write_en", int'(bus.write_en_o), 0);
    check("rst_ip_load",  int'(bus.ip_load), 0);
    check("rst_phase",    int'(bus.ip_phase), 0);
    check("rst_smp_cnt",  int'(bus.smp_cnt), 0);
    check("rst_err",      int'(bus.err_timeout), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      runFrame(i, vecs[i]);
      repeat (2) tick();
    end

    // int_req holds until acknowledged
    repeat (4) tick();
    check("int_hold", int'(bus.int_req), 1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    $display("int_ack pulse: int_req=%0d", int'(bus.int_req));
    check("int_ack_clr", int'(bus.int_req), 0);

    // Zero-length start with a simultaneous int_ack: the set must win
    bus.conf_len = '0;
    bus.start    = 1'b1;
    bus.int_ack  = 1'b1;
    tick();
    idleInputs();
    check("len0_ack_done", int'(bus.done), 1);
    tick();
    $display("len0+ack: int_req=%0d", int'(bus.int_req));
    check("len0_ack_int", int'(bus.int_req), 1);

    // An accepted start clears a pending int_req
    bus.conf_len = LEN_W'(1);
    bus.start    = 1'b1;
    tick();
    idleInputs();
    $display("start clears int_req: int_req=%0d busy=%0d", int'(bus.int_req), int'(bus.busy));
    check("start_clr_int", int'(bus.int_req), 0);
    check("start_busy", int'(bus.busy), 1);
    for (int k = 0; k < 40 && bus.busy; k++) tick();
    check("start_finish", int'(bus.busy), 0);
    repeat (2) tick();

`ifdef INTPOL2_CTRL_WDOG_EN
    // Watchdog: downstream stuck almost-full from cycle 3
    bus.wdog_limit = WDOG_W'(16);
    bus.conf_len   = LEN_W'(4);
    for (int c = 0; c < 30; c++) begin
      bus.start   = (c == 0);
      bus.afull_q = (c >= 3);
      #1;
      if (c == 18) check("wd_busy_before", int'(bus.busy), 1);
      if (c == 19) begin
        $display("watchdog: err=%0d int_req=%0d busy=%0d",
                 int'(bus.err_timeout), int'(bus.int_req), int'(bus.busy));
        check("wd_err", int'(bus.err_timeout), 1);
        check("wd_int_req", int'(bus.int_req), 1);
        check("wd_busy", int'(bus.busy), 0);
      end
      tick();
    end
    idleInputs();
`else
    check("err_tied_low", int'(bus.err_timeout), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
